// File: rtl/dclk_bcd_counter.sv
// Two-digit BCD modulo-MOD counter driven by rising edges of a divided-clock
// level. Each high period of dclk advances the count once; a one-cycle tc
// pulse marks the wrap from MOD-1 to 0 so a following stage can cascade.
// Loads are range-checked and a rejected load raises a one-cycle err pulse.
module dclk_bcd_counter #(
   parameter int MOD = 60
) (
   input  logic       clk,
   input  logic       rst_b,
   input  logic       clr,
   input  logic       dclk,
   input  logic       en,
   input  logic       ld,
   input  logic [7:0] d_in,
   output logic [7:0] q,
   output logic       tc,
   output logic       err
);

   // Terminal count MOD-1 expressed as two BCD digits.
   localparam logic [3:0]  LAST_TENS  = 4'((MOD - 1) / 10);
   localparam logic [3:0]  LAST_UNITS = 4'((MOD - 1) % 10);
   localparam logic [7:0]  LAST_Q     = {LAST_TENS, LAST_UNITS};
   localparam logic [31:0] MOD_U      = 32'(MOD);

   logic       dclk_q;
   logic       rise;
   logic [7:0] q_nxt;
   logic       tc_nxt;
   logic       err_nxt;

   // A load value is acceptable only if both digits are decimal and the
   // two-digit value lies inside the counting range.
   function automatic logic load_ok(input logic [7:0] v);
      logic [31:0] val;
      val = 32'(v[7:4]) * 32'd10 + 32'(v[3:0]);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (val < MOD_U);
   endfunction

   // Per-digit BCD increment with modulus wrap; returns the wrap flag too.
   function automatic logic [8:0] bcd_step(input logic [7:0] v);
      if (v == LAST_Q)
         return {1'b1, 8'h00};
      else if (v[3:0] == 4'd9)
         return {1'b0, v[7:4] + 4'd1, 4'd0};
      else
         return {1'b0, v[7:4], v[3:0] + 4'd1};
   endfunction

   // Rising edge of the dclk level; dclk_q resets high so a dclk already
   // high when reset releases never looks like an edge.
   assign rise = dclk & ~dclk_q;

   // Next-state selection: clr beats ld, ld beats a counted edge.
   always_comb begin
      q_nxt   = q;
      tc_nxt  = 1'b0;
      err_nxt = 1'b0;
      if (clr) begin
         q_nxt = 8'h00;
      end else if (ld) begin
         if (load_ok(d_in))
            q_nxt = d_in;
         else
            err_nxt = 1'b1;
      end else if (rise && en) begin
         {tc_nxt, q_nxt} = bcd_step(q);
      end
   end

   // State and output registers; the edge detector samples dclk every cycle.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         dclk_q <= 1'b1;
         q      <= 8'h00;
         tc     <= 1'b0;
         err    <= 1'b0;
      end else begin
         dclk_q <= dclk;
         q      <= q_nxt;
         tc     <= tc_nxt;
         err    <= err_nxt;
      end
   end

endmodule

// File: tb/tb_dclk_bcd_counter.sv
// Directed bench for dclk_bcd_counter at MOD=60: reset behaviour, edge
// counting with stretched dclk, carry and wrap, load validation, priority
// and asynchronous reset in mid-operation.
module tb_dclk_bcd_counter;

   logic       clk;
   logic       rst_b;
   logic       clr;
   logic       dclk;
   logic       en;
   logic       ld;
   logic [7:0] d_in;
   logic [7:0] q;
   logic       tc;
   logic       err;

   int total;
   int bad;

   dclk_bcd_counter #(.MOD(60)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .clr   (clr),
      .dclk  (dclk),
      .en    (en),
      .ld    (ld),
      .d_in  (d_in),
      .q     (q),
      .tc    (tc),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising clock edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Apply a one-cycle load request.
   task automatic load(input logic [7:0] v);
      ld   = 1'b1;
      d_in = v;
      tick();
      ld   = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_b = 1'b0;
      clr   = 1'b0;
      dclk  = 1'b1;
      en    = 1'b1;
      ld    = 1'b0;
      d_in  = 8'h00;

      // 1: reset with dclk high, then release and hold dclk high
      tick();
      tick();
      chk("rst_q", q, 8'h00);
      chk("rst_tc", {7'd0, tc}, 8'h00);
      chk("rst_err", {7'd0, err}, 8'h00);
      rst_b = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("rel_no_count_q", q, 8'h00);
      chk("rel_tc", {7'd0, tc}, 8'h00);

      // 2: six rises, the third held high for 4 clocks
      dclk = 1'b0;
      tick();
      for (int i = 1; i <= 6; i++) begin
         dclk = 1'b1;
         chk("pre_edge_q", q, 8'(i - 1));
         tick();
         chk("edge_q", q, 8'(i));
         if (i == 3) begin
            for (int k = 0; k < 3; k++) tick();
            chk("stretch_q", q, 8'h03);
         end
         dclk = 1'b0;
         tick();
      end
      chk("count6_q", q, 8'h06);

      // 3: units carry and modulus wrap
      load(8'h09);
      chk("ld09_q", q, 8'h09);
      dclk = 1'b1;
      tick();
      chk("carry_q", q, 8'h10);
      chk("carry_tc", {7'd0, tc}, 8'h00);
      dclk = 1'b0;
      tick();
      load(8'h59);
      chk("ld59_q", q, 8'h59);
      dclk = 1'b1;
      tick();
      chk("wrap_q", q, 8'h00);
      chk("wrap_tc", {7'd0, tc}, 8'h01);
      tick();
      chk("wrap_tc_drop", {7'd0, tc}, 8'h00);
      chk("wrap_hold_q", q, 8'h00);
      dclk = 1'b0;
      tick();

      // 4: rejected and accepted loads
      load(8'h23);
      chk("ld23_q", q, 8'h23);
      load(8'h5A);
      chk("bad5A_q", q, 8'h23);
      chk("bad5A_err", {7'd0, err}, 8'h01);
      tick();
      chk("err_drop", {7'd0, err}, 8'h00);
      load(8'h60);
      chk("bad60_q", q, 8'h23);
      chk("bad60_err", {7'd0, err}, 8'h01);
      load(8'h42);
      chk("ld42_q", q, 8'h42);
      chk("ld42_err", {7'd0, err}, 8'h00);

      // 5: priority clr > ld > rise, and rise with en=0
      load(8'h15);
      chk("ld15_q", q, 8'h15);
      clr  = 1'b1;
      dclk = 1'b1;
      tick();
      clr  = 1'b0;
      chk("clr_rise_q", q, 8'h00);
      dclk = 1'b0;
      tick();
      dclk = 1'b1;
      load(8'h30);
      chk("ld_rise_q", q, 8'h30);
      tick();
      chk("ld_rise_hold_q", q, 8'h30);
      dclk = 1'b0;
      tick();
      en   = 1'b0;
      dclk = 1'b1;
      tick();
      chk("en0_q", q, 8'h30);
      dclk = 1'b0;
      en   = 1'b1;
      tick();

      // 6: asynchronous reset between edges
      load(8'h37);
      chk("ld37_q", q, 8'h37);
      load(8'hAA);
      chk("badAA_err", {7'd0, err}, 8'h01);
      dclk = 1'b1;
      #2;
      rst_b = 1'b0;
      #1;
      chk("async_q", q, 8'h00);
      chk("async_tc", {7'd0, tc}, 8'h00);
      chk("async_err", {7'd0, err}, 8'h00);
      tick();
      rst_b = 1'b1;
      tick();
      tick();
      chk("post_rst_no_count", q, 8'h00);
      dclk = 1'b0;
      tick();
      dclk = 1'b1;
      tick();
      chk("post_rst_count", q, 8'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
